full_adder: RTL and testbench

- Registered full adder: sums operands a, b and carry-in ci; produces sum s and carry-out co.
- Default configuration is a single-bit cell. A WIDTH parameter widens it to a ripple-carry adder for datapath use.
- Outputs are registered on clk with a synchronous active-high reset, so the block drops straight into synchronous pipelines.
- Carry chain is built from per-bit full-adder cells: s_i = a_i ^ b_i ^ c_i; c_(i+1) = (a_i & b_i) | (ci_i & (a_i ^ b_i)).

---
 rtl/full_adder.sv | 66 ++++++
 tb/tb_full_adder.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/full_adder.sv
// -----------------------------------------------------------------------------
// full_adder
//
// Registered ripple-carry adder. With the default WIDTH=1 it is a single
// full-adder cell; wider settings chain WIDTH cells into a ripple-carry
// adder for datapath use. {co, s} is loaded with a + b + ci on every rising
// edge of clk, so the result appears one cycle after the inputs are sampled.
//
// Parameters:
//   WIDTH  operand and sum width in bits (1..64)
//
// Ports:
//   clk  in   rising-edge clock for all state
//   rst  in   synchronous reset, active-high; clears s and co
//   a    in   operand A, unsigned, WIDTH bits
//   b    in   operand B, unsigned, WIDTH bits
//   ci   in   carry-in, added at bit 0
//   s    out  registered sum, WIDTH bits
//   co   out  registered carry-out from the MSB cell
// -----------------------------------------------------------------------------
module full_adder #(
    parameter int unsigned WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             ci,
    output logic [WIDTH-1:0] s,
    output logic             co
);

    generate
        if (WIDTH < 1 || WIDTH > 64) begin : g_width_check
            $error("full_adder: WIDTH must be in 1..64");
        end
    endgenerate

    // carry[i] is the carry into cell i; carry[WIDTH] is the carry-out.
    logic [WIDTH:0]   carry;
    logic [WIDTH-1:0] sum_comb;

    // Ripple chain of full-adder cells. It is evaluated in a single process
    // so that the carry vector is not split across drivers.
    always_comb begin
        carry    = '0;
        sum_comb = '0;
        carry[0] = ci;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            sum_comb[i]  = a[i] ^ b[i] ^ carry[i];
            carry[i+1]   = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
        end
    end

    // Output register: reset wins over data in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            s  <= '0;
            co <= 1'b0;
        end else begin
            s  <= sum_comb;
            co <= carry[WIDTH];
        end
    end

endmodule

// File: tb/tb_full_adder.sv
// -----------------------------------------------------------------------------
// tb_full_adder
//
// Directed and random bench for full_adder at WIDTH=1, 4 and 8. Expected
// values come from plain integer addition a + b + ci split into sum and
// carry-out.
// -----------------------------------------------------------------------------
module tb_full_adder;

    logic clk;
    logic rst;

    logic       a1, b1, ci1, s1, co1;
    logic [3:0] a4, b4, s4;
    logic       ci4, co4;
    logic [7:0] a8, b8, s8;
    logic       ci8, co8;

    int checks;
    int failures;

    full_adder #(.WIDTH(1)) u_fa1 (
        .clk(clk), .rst(rst), .a(a1), .b(b1), .ci(ci1), .s(s1), .co(co1)
    );
    full_adder #(.WIDTH(4)) u_fa4 (
        .clk(clk), .rst(rst), .a(a4), .b(b4), .ci(ci4), .s(s4), .co(co4)
    );
    full_adder #(.WIDTH(8)) u_fa8 (
        .clk(clk), .rst(rst), .a(a8), .b(b8), .ci(ci8), .s(s8), .co(co8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: integer sum, returns {co, s} for a given width.
    function automatic logic [63:0] ref_sum(input int unsigned w, input longint unsigned x,
                                            input longint unsigned y, input bit c);
        longint unsigned total;
        longint unsigned mask;
        total = x + y + longint'(c);
        mask  = (64'd1 << (w + 1)) - 1;
        return total & mask;
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst = 1'b1;
        a1 = 1'b1; b1 = 1'b1; ci1 = 1'b1;
        a4 = 4'hF; b4 = 4'hF; ci4 = 1'b1;
        a8 = 8'hFF; b8 = 8'hFF; ci8 = 1'b1;

        // Reset held for two edges with all-ones data
        for (int i = 0; i < 2; i++) begin
            tick();
            chk("rst_w1", {co1, s1}, 64'd0);
            chk("rst_w4", {co4, s4}, 64'd0);
            chk("rst_w8", {co8, s8}, 64'd0);
        end

        // Release reset: 1+1+1 = 3 -> s=1, co=1
        rst = 1'b0;
        tick();
        chk("rst_release_w1", {co1, s1}, ref_sum(1, 1, 1, 1'b1));
        chk("rst_release_w1_const", {co1, s1}, 64'b11);

        // WIDTH=1 truth table
        for (int v = 0; v < 8; v++) begin
            logic [2:0] vv;
            vv  = 3'(v);
            a1  = vv[2];
            b1  = vv[1];
            ci1 = vv[0];
            tick();
            chk($sformatf("tt_w1_%0d", v), {co1, s1}, ref_sum(1, a1, b1, ci1));
        end

        // Reset mid-stream
        a1 = 1'b1; b1 = 1'b0; ci1 = 1'b1;
        tick();
        chk("mid_load", {co1, s1}, 64'b10);
        rst = 1'b1;
        tick();
        chk("mid_rst", {co1, s1}, 64'b00);
        rst = 1'b0;
        a1 = 1'b1; b1 = 1'b0; ci1 = 1'b0;
        tick();
        chk("mid_after", {co1, s1}, 64'b01);

        // Latency and hold: a toggles 0->1->0 within one period
        #2 a1 = 1'b0;
        #2 chk("hold_a0", {co1, s1}, 64'b01);
        a1 = 1'b1;
        #2 chk("hold_a1", {co1, s1}, 64'b01);
        a1 = 1'b0;
        tick();
        chk("hold_sampled", {co1, s1}, 64'b00);

        // WIDTH=4 wrap cases
        a4 = 4'd15; b4 = 4'd0; ci4 = 1'b1;
        tick();
        chk("w4_wrap", {co4, s4}, {59'd0, 1'b1, 4'd0});
        a4 = 4'd15; b4 = 4'd15; ci4 = 1'b1;
        tick();
        chk("w4_max", {co4, s4}, {59'd0, 1'b1, 4'd15});
        a4 = 4'd9; b4 = 4'd5; ci4 = 1'b0;
        tick();
        chk("w4_9p5", {co4, s4}, {59'd0, 1'b0, 4'd14});
        a4 = 4'd0; b4 = 4'd0; ci4 = 1'b0;
        tick();
        chk("w4_zero", {co4, s4}, 64'd0);

        // WIDTH=8 boundaries
        a8 = 8'hFF; b8 = 8'h00; ci8 = 1'b1;
        tick();
        chk("w8_wrap", {co8, s8}, 64'h100);
        a8 = 8'hFF; b8 = 8'hFF; ci8 = 1'b1;
        tick();
        chk("w8_max", {co8, s8}, 64'h1FF);

        // WIDTH=8 random back-to-back
        for (int n = 0; n < 1000; n++) begin
            a8  = 8'($urandom_range(0, 255));
            b8  = 8'($urandom_range(0, 255));
            ci8 = 1'($urandom_range(0, 1));
            a4  = 4'($urandom_range(0, 15));
            b4  = 4'($urandom_range(0, 15));
            ci4 = 1'($urandom_range(0, 1));
            tick();
            chk($sformatf("w8_rand_%0d", n), {co8, s8}, ref_sum(8, a8, b8, ci8));
            chk($sformatf("w4_rand_%0d", n), {co4, s4}, ref_sum(4, a4, b4, ci4));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
